execution_unit: RTL and testbench
=================================

EXECUTION_UNIT -- requirements
Module: execution_unit

Interface
REQ-001 Parameter WIDTH, default 32: operand and result width in bits; shift amount is the low log2(WIDTH) bits of opB.
REQ-002 clk, input, 1: single clock; all state updates on its rising edge.
REQ-003 rst_n, input, 1: asynchronous active-low reset.
REQ-004 in_valid, input, 1: operation request for this cycle.
REQ-005 func, input, 3: primary operation select (RV32 funct3 encoding).
REQ-006 auxFunc, input, 7: secondary operation select (RV32 funct7 encoding).
REQ-007 opA, input, WIDTH: first operand.
REQ-008 opB, input, WIDTH: second operand.
REQ-009 out, output, WIDTH: registered result.
REQ-010 out_valid, output, 1: out holds the result of the request accepted on the previous edge.
REQ-011 illegal, output, 1: the accepted func/auxFunc combination is unsupported.

Function
REQ-012 Latency is exactly one cycle: a rising edge with in_valid=1 loads out, illegal, and out_valid=1.
REQ-013 Rising edge with in_valid=0: out_valid<=0; out and illegal hold their values.
REQ-014 No backpressure; a new request is accepted every cycle.
REQ-015 auxFunc=0000000 decodes: 000 ADD, 001 SLL, 010 SLT (signed, result 1/0), 011 SLTU (unsigned, result 1/0), 100 XOR, 101 SRL, 110 OR, 111 AND.
REQ-016 auxFunc=0100000 decodes: 000 SUB (opA-opB), 101 SRA (arithmetic, sign-filled).
REQ-017 ADD and SUB wrap modulo 2^WIDTH; carry and overflow are discarded.
REQ-018 Shifts use only opB[log2(WIDTH)-1:0]; upper opB bits are ignored; shift by 0 returns opA.
REQ-019 Any other func/auxFunc combination is illegal: out<=0, illegal<=1.
REQ-020 Every legal operation loads illegal<=0.

Reset
REQ-021 While rst_n=0: out=0, out_valid=0, illegal=0, applied immediately without waiting for clk.
REQ-022 A request presented on the same edge that reset is asserted is discarded.
REQ-023 After rst_n deasserts, the first rising edge with in_valid=1 is accepted normally.

Configuration
REQ-024 Macro EXECUTION_UNIT_MULDIV_EN enables the RV32M group at auxFunc=0000001.
REQ-025 With EXECUTION_UNIT_MULDIV_EN, func selects: 000 MUL (low WIDTH bits), 001 MULH (signed x signed, high bits), 010 MULHSU (signed opA x unsigned opB, high bits), 011 MULHU (unsigned, high bits), 100 DIV, 101 DIVU, 110 REM, 111 REMU. All RV32M ops have the same one-cycle latency.
REQ-026 Division rounds toward zero; REM takes the sign of the dividend.
REQ-027 Divide by zero: DIV and DIVU return all ones; REM and REMU return opA.
REQ-028 Signed overflow (most-negative value / -1): DIV returns the most-negative value; REM returns 0.
REQ-029 Without EXECUTION_UNIT_MULDIV_EN, auxFunc=0000001 is illegal per REQ-019, and no multiplier or divider logic is synthesized.

Verification
REQ-030 Reset, then func=000 aux=0000000 opA=1 opB=2 in_valid=1 -> next edge out=00000003, out_valid=1, illegal=0; with in_valid=0 on the following edge -> out_valid=0, out holds 00000003.
REQ-031 SUB 00000000-00000001 -> FFFFFFFF; SLT FFFFFFFF vs 00000001 -> 1; SLTU with the same operands -> 0.
REQ-032 SRA 80000000 by opB=00000024 (effective shift 4) -> F8000000; SRL with the same operands -> 08000000; SLL 00000001 by 0000001F -> 80000000.
REQ-033 func=000 aux=0100001 -> out=0, illegal=1; a following legal AND F0F0F0F0 & FF00FF00 -> F000F000, illegal=0.
REQ-034 With EXECUTION_UNIT_MULDIV_EN: DIV 80000000/FFFFFFFF -> 80000000; REM of the same operands -> 0; DIVU 7/0 -> FFFFFFFF; REMU 7/0 -> 7; MULHU FFFFFFFF*FFFFFFFF -> FFFFFFFE. Without the macro, the same requests -> illegal=1.
REQ-035 Assert rst_n=0 mid-stream between edges -> out, out_valid and illegal go to 0 immediately; the next accepted request produces a correct result.

Source files
------------

// File: rtl/execution_unit.sv
// Single-cycle RV32I-style integer execution unit with a registered result.
// Define EXECUTION_UNIT_MULDIV_EN to add the RV32M multiply/divide group (auxFunc=0000001).
module execution_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [2:0]       func,
    input  logic [6:0]       auxFunc,
    input  logic [WIDTH-1:0] opA,
    input  logic [WIDTH-1:0] opB,
    output logic [WIDTH-1:0] out,
    output logic             out_valid,
    output logic             illegal
);

    localparam int unsigned ShW = $clog2(WIDTH);
    localparam logic [6:0] AuxBase   = 7'b0000000;
    localparam logic [6:0] AuxAlt    = 7'b0100000;

    logic [WIDTH-1:0] out_q, res_d;
    logic             out_valid_q;
    logic             illegal_q, illegal_d;
    logic [ShW-1:0]   shamt;

    assign shamt = opB[ShW-1:0];

`ifdef EXECUTION_UNIT_MULDIV_EN
    localparam logic [6:0] AuxMulDiv = 7'b0000001;
    localparam logic [WIDTH-1:0] MinNeg = {1'b1, {(WIDTH-1){1'b0}}};

    logic               a_sgn, b_sgn;
    logic [2*WIDTH-1:0] a_x, b_x, prod;
    logic               div_zero, div_ovf;
    logic [WIDTH-1:0]   quot_s, rem_s, quot_u, rem_u;

    // One shared multiplier: operands are sign- or zero-extended per func so the
    // low 2*WIDTH bits of the product are correct for every MUL variant.
    assign a_sgn = (func[1:0] == 2'b01) || (func[1:0] == 2'b10);
    assign b_sgn = (func[1:0] == 2'b01);
    assign a_x   = {{WIDTH{a_sgn & opA[WIDTH-1]}}, opA};
    assign b_x   = {{WIDTH{b_sgn & opB[WIDTH-1]}}, opB};
    assign prod  = a_x * b_x;

    assign div_zero = (opB == '0);
    assign div_ovf  = (opA == MinNeg) && (opB == '1);

    always_comb begin
        quot_u = '1;
        rem_u  = opA;
        quot_s = '1;
        rem_s  = opA;
        if (!div_zero) begin
            quot_u = opA / opB;
            rem_u  = opA % opB;
            if (div_ovf) begin
                quot_s = MinNeg;
                rem_s  = '0;
            end else begin
                quot_s = $signed(opA) / $signed(opB);
                rem_s  = $signed(opA) % $signed(opB);
            end
        end
    end
`endif

    always_comb begin
        res_d     = '0;
        illegal_d = 1'b0;
        case (auxFunc)
            AuxBase: begin
                case (func)
                    3'b000: res_d = opA + opB;
                    3'b001: res_d = opA << shamt;
                    3'b010: res_d = {{(WIDTH-1){1'b0}}, $signed(opA) < $signed(opB)};
                    3'b011: res_d = {{(WIDTH-1){1'b0}}, opA < opB};
                    3'b100: res_d = opA ^ opB;
                    3'b101: res_d = opA >> shamt;
                    3'b110: res_d = opA | opB;
                    default: res_d = opA & opB;
                endcase
            end
            AuxAlt: begin
                if (func == 3'b000) begin
                    res_d = opA - opB;
                end else if (func == 3'b101) begin
                    res_d = $signed(opA) >>> shamt;
                end else begin
                    illegal_d = 1'b1;
                end
            end
`ifdef EXECUTION_UNIT_MULDIV_EN
            AuxMulDiv: begin
                case (func)
                    3'b000: res_d = prod[WIDTH-1:0];
                    3'b001, 3'b010, 3'b011: res_d = prod[2*WIDTH-1:WIDTH];
                    3'b100: res_d = quot_s;
                    3'b101: res_d = quot_u;
                    3'b110: res_d = rem_s;
                    default: res_d = rem_u;
                endcase
            end
`endif
            default: illegal_d = 1'b1;
        endcase
    end

    // Idle cycles only drop out_valid; result and illegal flag hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q       <= '0;
            out_valid_q <= 1'b0;
            illegal_q   <= 1'b0;
        end else begin
            out_valid_q <= in_valid;
            if (in_valid) begin
                out_q     <= res_d;
                illegal_q <= illegal_d;
            end
        end
    end

    assign out       = out_q;
    assign out_valid = out_valid_q;
    assign illegal   = illegal_q;

endmodule

// File: tb/tb_execution_unit.sv
// Bench for execution_unit: directed vector table, hand sequences and a random run
// against an arithmetic reference model (honours EXECUTION_UNIT_MULDIV_EN).
module tb_execution_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [2:0]  func = '0;
    logic [6:0]  auxFunc = '0;
    logic [31:0] opA = '0;
    logic [31:0] opB = '0;
    logic [31:0] out;
    logic        out_valid;
    logic        illegal;

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_out = '0;
    logic        exp_ill = 1'b0;

    typedef struct {
        string       name;
        logic [2:0]  f;
        logic [6:0]  aux;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        ill;
    } vec_t;

    vec_t vecs[$];

    execution_unit #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .func      (func),
        .auxFunc   (auxFunc),
        .opA       (opA),
        .opB       (opB),
        .out       (out),
        .out_valid (out_valid),
        .illegal   (illegal)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    // Reference model from the ISA rules, using plain integer arithmetic.
    task automatic model(input logic [2:0] f, input logic [6:0] aux, input logic [31:0] a,
                         input logic [31:0] b, output logic [31:0] r, output logic ill);
        int          sa = $signed(a);
        int          sb = $signed(b);
        int unsigned sh = 32'(b[4:0]);
        longint      ps;
        longint unsigned pu;
        r   = 32'h0;
        ill = 1'b0;
        if (aux == 7'd0) begin
            case (f)
                3'd0: r = a + b;
                3'd1: r = a << sh;
                3'd2: r = (sa < sb) ? 32'd1 : 32'd0;
                3'd3: r = (a < b) ? 32'd1 : 32'd0;
                3'd4: r = a ^ b;
                3'd5: r = a >> sh;
                3'd6: r = a | b;
                default: r = a & b;
            endcase
        end else if (aux == 7'b0100000 && f == 3'd0) begin
            r = a - b;
        end else if (aux == 7'b0100000 && f == 3'd5) begin
            r = sa >>> sh;
`ifdef EXECUTION_UNIT_MULDIV_EN
        end else if (aux == 7'd1) begin
            case (f)
                3'd0: r = a * b;
                3'd1: begin ps = longint'(sa) * longint'(sb); r = ps[63:32]; end
                3'd2: begin ps = longint'(sa) * longint'({32'h0, b}); r = ps[63:32]; end
                3'd3: begin pu = {32'h0, a} * {32'h0, b}; r = pu[63:32]; end
                3'd4: r = (b == 0) ? 32'hFFFF_FFFF :
                          (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? a : sa / sb;
                3'd5: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
                3'd6: r = (b == 0) ? a :
                          (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? 32'h0 : sa % sb;
                default: r = (b == 0) ? a : a % b;
            endcase
`endif
        end else begin
            ill = 1'b1;
        end
    endtask

    // One clock of stimulus; checks the registered outputs just after the edge.
    task automatic step(input string name, input logic v, input logic [2:0] f,
                        input logic [6:0] aux, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        in_valid = v;
        func     = f;
        auxFunc  = aux;
        opA      = a;
        opB      = b;
        @(posedge clk);
        #1;
        check({name, ".valid"}, {31'h0, out_valid}, {31'h0, v});
        check({name, ".out"}, out, exp_out);
        check({name, ".ill"}, {31'h0, illegal}, {31'h0, exp_ill});
    endtask

    initial begin
        logic [31:0] r;
        logic        il;
        logic [6:0]  aux;
        logic        v;

        vecs.push_back('{"sub",     3'd0, 7'h20, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 1'b0});
        vecs.push_back('{"slt",     3'd2, 7'h00, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1'b0});
        vecs.push_back('{"sltu",    3'd3, 7'h00, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b0});
        vecs.push_back('{"sra",     3'd5, 7'h20, 32'h8000_0000, 32'h0000_0024, 32'hF800_0000, 1'b0});
        vecs.push_back('{"srl",     3'd5, 7'h00, 32'h8000_0000, 32'h0000_0024, 32'h0800_0000, 1'b0});
        vecs.push_back('{"sll",     3'd1, 7'h00, 32'h0000_0001, 32'h0000_001F, 32'h8000_0000, 1'b0});
        vecs.push_back('{"sll0",    3'd1, 7'h00, 32'h1234_5678, 32'hFFFF_FFE0, 32'h1234_5678, 1'b0});
        vecs.push_back('{"ill21",   3'd0, 7'h21, 32'h1234_5678, 32'h1111_1111, 32'h0000_0000, 1'b1});
        vecs.push_back('{"and",     3'd7, 7'h00, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1'b0});
        vecs.push_back('{"ill20",   3'd1, 7'h20, 32'h0000_0005, 32'h0000_0001, 32'h0000_0000, 1'b1});
        vecs.push_back('{"addwrap", 3'd0, 7'h00, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001, 1'b0});
        vecs.push_back('{"xor",     3'd4, 7'h00, 32'hAAAA_5555, 32'hFFFF_0000, 32'h5555_5555, 1'b0});
        vecs.push_back('{"or",      3'd6, 7'h00, 32'h0F00_0000, 32'h0000_00F0, 32'h0F00_00F0, 1'b0});
`ifdef EXECUTION_UNIT_MULDIV_EN
        vecs.push_back('{"divovf",  3'd4, 7'h01, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0});
        vecs.push_back('{"removf",  3'd6, 7'h01, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0});
        vecs.push_back('{"divu0",   3'd5, 7'h01, 32'h0000_0007, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0});
        vecs.push_back('{"remu0",   3'd7, 7'h01, 32'h0000_0007, 32'h0000_0000, 32'h0000_0007, 1'b0});
        vecs.push_back('{"mulhu",   3'd3, 7'h01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0});
        vecs.push_back('{"divneg",  3'd4, 7'h01, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 1'b0});
        vecs.push_back('{"remneg",  3'd6, 7'h01, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 1'b0});
        vecs.push_back('{"mul",     3'd0, 7'h01, 32'h0001_0003, 32'h0001_0002, 32'h0005_0006, 1'b0});
`else
        vecs.push_back('{"divovf",  3'd4, 7'h01, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1});
        vecs.push_back('{"removf",  3'd6, 7'h01, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1});
        vecs.push_back('{"divu0",   3'd5, 7'h01, 32'h0000_0007, 32'h0000_0000, 32'h0000_0000, 1'b1});
        vecs.push_back('{"remu0",   3'd7, 7'h01, 32'h0000_0007, 32'h0000_0000, 32'h0000_0000, 1'b1});
        vecs.push_back('{"mulhu",   3'd3, 7'h01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1});
`endif

        // Reset state
        #2;
        check("rst.out", out, 32'h0);
        check("rst.valid", {31'h0, out_valid}, 32'h0);
        check("rst.ill", {31'h0, illegal}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // First op after reset, then an idle cycle that must hold the result
        exp_out = 32'h3; exp_ill = 1'b0;
        step("add", 1'b1, 3'd0, 7'h00, 32'h1, 32'h2);
        step("idle", 1'b0, 3'd1, 7'h7F, 32'hDEAD_BEEF, 32'h5);

        foreach (vecs[i]) begin
            exp_out = vecs[i].res;
            exp_ill = vecs[i].ill;
            step(vecs[i].name, 1'b1, vecs[i].f, vecs[i].aux, vecs[i].a, vecs[i].b);
        end

        // Illegal flag must hold across an idle cycle
        exp_out = 32'h0; exp_ill = 1'b1;
        step("ill", 1'b1, 3'd2, 7'h20, 32'h1, 32'h2);
        step("illhold", 1'b0, 3'd0, 7'h00, 32'h1, 32'h2);

        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(0, 3))
                0: aux = 7'h00;
                1: aux = 7'h20;
                2: aux = 7'h01;
                default: aux = 7'($urandom);
            endcase
            v = ($urandom_range(0, 4) != 0);
            func = 3'($urandom);
            opA = $urandom;
            opB = ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom;
            if ($urandom_range(0, 9) == 0) opA = 32'h8000_0000;
            if ($urandom_range(0, 9) == 0) opB = 32'hFFFF_FFFF;
            if (v) begin
                model(func, aux, opA, opB, r, il);
                exp_out = r;
                exp_ill = il;
            end
            step("rnd", v, func, aux, opA, opB);
        end

        // Reset asserted between edges clears outputs immediately
        exp_out = 32'hF000_F000; exp_ill = 1'b0;
        step("prerst", 1'b1, 3'd7, 7'h00, 32'hF0F0_F0F0, 32'hFF00_FF00);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst.out", out, 32'h0);
        check("midrst.valid", {31'h0, out_valid}, 32'h0);
        check("midrst.ill", {31'h0, illegal}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        exp_out = 32'h0000_0000; exp_ill = 1'b0;
        step("postrst", 1'b1, 3'd0, 7'h20, 32'h1234_5678, 32'h1234_5678);
        exp_out = 32'h0000_0010;
        step("postrst2", 1'b1, 3'd0, 7'h00, 32'h0000_0007, 32'h0000_0009);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
